apb_requester: RTL and testbench
================================

# apb_requester

Single-outstanding APB initiator that turns a valid/ready command stream into APB3 transfers. It drives `psel`, `penable`, `paddr`, `pwrite` and `pwdata`, samples `prdata`, `pready` and `pslverr`, and returns one response per command. It is the master side of the APB RAM model in `soc_top`, and replaces the testbench-driven APB stimulus so that SoC-level tests run through a real initiator. A wait-state timeout keeps a hung completer from stalling a test.

## Interface
- `ADDR_W`, 32, APB address width.
- `DATA_W`, 32, APB data width (byte-lane aligned, multiple of 8).
- `TIMEOUT`, 256, maximum ACCESS cycles before abort (≥2); a value of 0 disables the timeout.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: command valid.
- `req_ready` out 1: command accepted when `req_valid & req_ready` at a rising edge.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_rdata` out DATA_W: read data; 0 for writes and errors.
- `rsp_err` out 1: `pslverr`, misalignment or timeout.
- `rsp_timeout` out 1: error was caused by timeout.
- `psel`, `penable`, `pwrite` out 1: APB control.
- `paddr` out ADDR_W: APB address.
- `pwdata` out DATA_W: APB write data.
- `prdata` in DATA_W: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: `req_ready`=1. On accept, latch write/addr/wdata.
  - If `req_addr[1:0]`≠0, go to RESP with `rsp_err`=1 and issue no APB transfer.
  - Otherwise go to SETUP.
- SETUP: `psel`=1, `penable`=0. Drive address, write and data from the latches. Go to ACCESS unconditionally.
- ACCESS: `psel`=1, `penable`=1, with all APB outputs held stable.
  - On `pready`=1: capture `prdata` (reads only) and `pslverr`, then go to RESP.
  - Otherwise increment the wait counter. When it reaches TIMEOUT−1 with `pready` still low, go to RESP with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0. `psel` drops on the next cycle. This is a deliberate abort.
- RESP: `rsp_valid`=1; response fields are stable until the handshake. On `rsp_ready`, go to IDLE.
- `req_ready` is 0 outside IDLE. There is never more than one transfer outstanding.
- `pwdata` = latched wdata on writes and 0 on reads.
- `paddr` holds its last value in IDLE. `psel`/`penable` are 0 in IDLE and RESP.
- `rsp_rdata` = 0 for writes, even if `prdata` is nonzero.
- `pslverr` is only sampled in the same cycle as `pready`=1.
- Wait counter:
  - width is $clog2(TIMEOUT+1);
  - clears on entry to SETUP;
  - saturates and never wraps.

## Timing
- Reset values: `req_ready`=0 while `rst` is asserted and 1 in the first cycle after release. All other outputs are 0: `rsp_valid`, `rsp_rdata`, `rsp_err`, `rsp_timeout`, `psel`, `penable`, `pwrite`, `paddr`, `pwdata`.
- All outputs are registered, with no combinational input-to-output paths.
- Command accepted at edge T:
  - SETUP visible in T..T+1;
  - ACCESS visible from T+1;
  - with zero wait states, `rsp_valid` rises after edge T+2.
  - Latency is 3 + W cycles, where W is the number of low-`pready` cycles in ACCESS.
- Misaligned command: `rsp_valid` one cycle after accept.
- Minimum issue interval is 4 cycles: accept, SETUP, ACCESS, RESP with immediate `rsp_ready`. The next accept is possible at the edge after the RESP handshake.
- Reset mid-transfer:
  - all outputs clear immediately and asynchronously;
  - the transfer is lost and no response is produced;
  - the FSM returns to IDLE.
- If `rsp_ready` is held high, the response still lasts one cycle minimum.

## Structure
- `apb_pkg`: `apb_state_e` enum (IDLE/SETUP/ACCESS/RESP), `APB_ADDR_W`/`APB_DATA_W` defaults, and the `APB_ALIGN_MASK` constant. This package is shared with future APB completers.
- One sub-module, `apb_wait_timer`: a saturating counter with inputs clear, enable and limit, and output `expired`. It can be reused by a future APB completer monitor.

## Test plan
- Aligned write, addr 0x10, data 0xCAFEF00D, `pready` tied 1:
  - `psel` high for exactly 2 cycles;
  - `penable` high in the 2nd cycle only;
  - RAM word 4 = 0xCAFEF00D;
  - `rsp_err`=0, `rsp_rdata`=0.
- Read of addr 0x10 with 3 wait states:
  - `paddr`, `pwrite`=0 and `pwdata`=0 stable for 4 ACCESS cycles;
  - `rsp_valid` 6 cycles after accept;
  - `rsp_rdata`=0xCAFEF00D.
- Misaligned read, addr 0x13:
  - `psel` never asserts;
  - `rsp_valid` next cycle with `rsp_err`=1 and `rsp_timeout`=0.
- TIMEOUT=16 with `pready` stuck at 0:
  - exactly 16 ACCESS cycles;
  - then `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0;
  - `psel` low the following cycle.
- `pslverr`=1 with `pready` on a read returning 0x12345678:
  - `rsp_err`=1 and `rsp_timeout`=0;
  - hold `rsp_ready`=0 for 5 cycles and check that all response fields stay stable and `req_ready` stays 0.
- Assert `rst` during ACCESS:
  - all outputs 0 in the same cycle;
  - after release, a write to 0x20 completes normally with no stale response.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : apb_pkg
// Purpose  : Shared APB definitions: FSM state encoding, default bus widths,
//            word-alignment mask and an alignment helper. Intended to be
//            imported by both initiators and completers.
// Contents : apb_state_e, APB_ADDR_W, APB_DATA_W, APB_ALIGN_MASK,
//            apb_addr_aligned()
// Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Address LSBs that must be zero for a word-aligned transfer.
  localparam logic [1:0] APB_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  function automatic logic apb_addr_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & APB_ALIGN_MASK) == 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : apb_wait_timer
// Purpose  : Saturating wait-state counter. Counts enabled cycles since the
//            last clear and flags when the count has reached limit-1, i.e. the
//            current cycle is the limit-th counted cycle. A limit of zero
//            disables expiry.
// Ports    : clk, rst     - clock, asynchronous active-high reset
//            clear        - synchronous clear (wins over enable)
//            enable       - count this cycle
//            limit        - expiry threshold
//            expired      - count >= limit-1 and limit != 0
// Revision : 1.0 - initial release
// ============================================================================
module apb_wait_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturate at all-ones so a long stall can never wrap back below the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (limit != '0) && (cnt_q >= (limit - 1'b1));

endmodule
`default_nettype wire

// File: rtl/apb_requester.sv
`default_nettype none
// ============================================================================
// Module   : apb_requester
// Purpose  : Single-outstanding APB3 initiator. Converts a valid/ready command
//            stream into APB transfers and returns one response per command.
//            Misaligned commands are answered with an error and never reach
//            the bus; a wait-state timeout aborts transfers to a hung completer.
// Ports    : clk, rst                       - clock, async active-high reset
//            req_valid/req_ready            - command handshake
//            req_write/req_addr/req_wdata   - command payload
//            rsp_valid/rsp_ready            - response handshake
//            rsp_rdata/rsp_err/rsp_timeout  - response payload
//            psel/penable/pwrite/paddr/pwdata - APB request
//            prdata/pready/pslverr          - APB completion
// Revision : 1.0 - initial release
// ============================================================================
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // At least one bit so that TIMEOUT=0 (timeout disabled) still elaborates.
  localparam int               CNT_W         = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT);

  apb_state_e state_q, state_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;

  logic accept;
  logic aligned;
  logic access_done;
  logic access_abort;
  logic timer_expired;

  assign accept       = req_valid && req_ready_q;
  assign aligned      = apb_addr_aligned(req_addr[1:0]);
  assign access_done  = (state_q == ACCESS) && pready;
  // A completing pready in the last allowed cycle wins over the abort.
  assign access_abort = (state_q == ACCESS) && !pready && timer_expired;

  // Counter is cleared during SETUP so it reads zero in the first ACCESS cycle
  // and counts only the low-pready ACCESS cycles.
  apb_wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == SETUP),
    .enable  ((state_q == ACCESS) && !pready),
    .limit   (TIMEOUT_LIMIT),
    .expired (timer_expired)
  );

  // --------------------------------------------------------------------------
  // State register (all outputs are registered here as well)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = aligned ? SETUP : RESP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (access_done || access_abort) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: next values of the registered outputs, derived from the
  // upcoming state so every output lines up with the state it belongs to.
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready_d   = (state_d == IDLE);
    psel_d        = (state_d == SETUP) || (state_d == ACCESS);
    penable_d     = (state_d == ACCESS);

    // The bus request fields double as the command latches; they only load
    // on an accepted aligned command and otherwise hold their last value.
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;

    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    if (accept && aligned) begin
      pwrite_d = req_write;
      paddr_d  = req_addr;
      pwdata_d = req_write ? req_wdata : '0;
    end

    if (accept && !aligned) begin
      rsp_valid_d   = 1'b1;
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b0;
      rsp_rdata_d   = '0;
    end

    if (access_done) begin
      rsp_valid_d   = 1'b1;
      rsp_err_d     = pslverr;
      rsp_timeout_d = 1'b0;
      rsp_rdata_d   = (pwrite_q || pslverr) ? '0 : prdata;
    end else if (access_abort) begin
      rsp_valid_d   = 1'b1;
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_rdata_d   = '0;
    end

    if ((state_q == RESP) && rsp_ready) begin
      rsp_valid_d   = 1'b0;
      rsp_err_d     = 1'b0;
      rsp_timeout_d = 1'b0;
      rsp_rdata_d   = '0;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_requester
// Purpose  : Self-checking bench for apb_requester. A driver issues commands
//            and pushes the expected response into a queue; a monitor pops
//            and compares when each response handshakes. An APB RAM completer
//            with programmable wait states and error injection sits on the bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_requester;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  apb_requester #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        to;
    logic [31:0] rdata;
    int          lat;     // negedges from accept sample to first response sample
    int          acc;     // ACCESS cycles on the bus
    int          setup;   // SETUP cycles on the bus
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_done = 0;

  // Completer configuration for the transfer in flight.
  int cur_wait = 0;
  bit cur_err  = 1'b0;
  int hold_req = 0;

  logic [31:0] ram       [0:63] = '{default: '0};
  logic [31:0] model_mem [0:63] = '{default: '0};

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // --------------------------------------------------------------------------
  // APB RAM completer: pready rises after cur_wait low ACCESS cycles.
  // Outside a ready cycle, pready/pslverr/prdata carry noise the DUT must ignore.
  // --------------------------------------------------------------------------
  initial begin : completer
    int acc_n;
    acc_n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pready  = 1'b0;
        pslverr = 1'b0;
        acc_n   = 0;
      end else if (psel && penable) begin
        if (acc_n == cur_wait) begin
          pready  = 1'b1;
          pslverr = cur_err;
          prdata  = pwrite ? ($urandom() | 32'h1) : ram[paddr[7:2]];
          if (pwrite && !cur_err) ram[paddr[7:2]] = pwdata;
        end else begin
          pready  = 1'b0;
          pslverr = 1'($urandom_range(0, 1));
          prdata  = $urandom();
        end
        acc_n++;
      end else begin
        acc_n   = 0;
        pready  = 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom();
      end
    end
  end

  // Response back-pressure: forced low for hold_req response cycles, else random.
  initial begin : rsp_ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rsp_valid && hold_req > 0) begin
        rsp_ready = 1'b0;
        hold_req--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  initial begin : monitor
    int          cyc, acc_cyc, rsp_cyc, setup_n, access_n;
    logic        in_resp;
    logic [31:0] s_addr, s_wdata, r_rdata;
    logic        s_write, r_err, r_to;
    exp_t        e;
    cyc = 0; acc_cyc = 0; rsp_cyc = 0; setup_n = 0; access_n = 0;
    in_resp = 1'b0;
    s_addr = '0; s_wdata = '0; s_write = 1'b0;
    r_rdata = '0; r_err = 1'b0; r_to = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_resp  = 1'b0;
        setup_n  = 0;
        access_n = 0;
      end else begin
        cyc++;
        if (req_valid && req_ready) begin
          acc_cyc  = cyc;
          setup_n  = 0;
          access_n = 0;
        end
        if (psel && !penable) begin
          setup_n++;
          s_addr  = paddr;
          s_write = pwrite;
          s_wdata = pwdata;
        end
        if (psel && penable) begin
          access_n++;
          chk("access_hold", {paddr, pwdata, 31'd0, pwrite}, {s_addr, s_wdata, 31'd0, s_write});
        end
        if (rsp_valid) begin
          if (!in_resp) begin
            in_resp = 1'b1;
            rsp_cyc = cyc;
            r_rdata = rsp_rdata;
            r_err   = rsp_err;
            r_to    = rsp_timeout;
            chk("bus_idle_in_resp", {psel, penable}, 2'b00);
          end else begin
            chk("rsp_stable", {rsp_rdata, rsp_err, rsp_timeout}, {r_rdata, r_err, r_to});
          end
          chk("req_ready_low_in_resp", req_ready, 1'b0);
          if (rsp_ready) begin
            in_resp = 1'b0;
            if (exp_q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_rsp: got response err=%0b rdata=%0h with nothing outstanding",
                       rsp_err, rsp_rdata);
            end else begin
              e = exp_q.pop_front();
              chk("rsp_err", rsp_err, e.err);
              chk("rsp_timeout", rsp_timeout, e.to);
              chk("rsp_rdata", rsp_rdata, e.rdata);
              chk("latency", rsp_cyc - acc_cyc, e.lat);
              chk("access_cycles", access_n, e.acc);
              chk("setup_cycles", setup_n, e.setup);
              if (e.setup == 1) begin
                chk("paddr", s_addr, e.addr);
                chk("pwrite", s_write, e.wr);
                chk("pwdata", s_wdata, e.wdata);
              end
            end
            n_done++;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver with reference model
  // --------------------------------------------------------------------------
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input int waits, input bit err, input int hold);
    exp_t e;
    int   idx;
    int   n;
    cur_wait = waits;
    cur_err  = err;
    hold_req = hold;
    idx      = int'(addr[7:2]);
    e.addr   = addr;
    e.wr     = wr;
    e.wdata  = wr ? data : 32'h0;
    e.rdata  = 32'h0;
    e.to     = 1'b0;
    if (addr[1:0] != 2'b00) begin
      e.err = 1'b1; e.lat = 1; e.acc = 0; e.setup = 0;
    end else if (waits >= TMO) begin
      e.err = 1'b1; e.to = 1'b1; e.acc = TMO; e.lat = TMO + 2; e.setup = 1;
    end else begin
      e.err = err; e.acc = waits + 1; e.lat = waits + 3; e.setup = 1;
      if (!wr && !err) e.rdata = model_mem[idx];
      if (wr && !err) model_mem[idx] = data;
    end
    exp_q.push_back(e);

    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    req_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 50) begin
        fail_bound("accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = $urandom();
    req_wdata = $urandom();
  endtask

  task automatic wait_rsp();
    int target;
    target = n_done + 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (n_done >= target) return;
    end
    fail_bound("response");
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input int waits, input bit err, input int hold);
    issue(wr, addr, data, waits, err, hold);
    wait_rsp();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {req_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite}, 7'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_paddr"}, paddr, 32'h0);
    chk({tag, "_pwdata"}, pwdata, 32'h0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench timed out");
  end

  initial begin : driver
    bit          wr;
    logic [31:0] addr;
    int          waits;
    int          n;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("req_ready_after_reset", req_ready, 1'b1);

    // Aligned write, zero wait states
    xfer(1'b1, 32'h10, 32'hCAFEF00D, 0, 1'b0, 0);
    chk("ram_word4", ram[4], 32'hCAFEF00D);

    // Read back with 3 wait states
    xfer(1'b0, 32'h10, 32'h0, 3, 1'b0, 0);

    // Misaligned read: no bus activity
    xfer(1'b0, 32'h13, 32'h0, 0, 1'b0, 0);

    // Stuck completer: abort after TMO ACCESS cycles
    xfer(1'b0, 32'h8, 32'h0, 1000, 1'b0, 0);

    // Boundary: ready in the very last allowed cycle completes normally
    xfer(1'b1, 32'h4, 32'h0BADBEEF, TMO - 1, 1'b0, 0);
    xfer(1'b0, 32'h4, 32'h0, TMO, 1'b0, 0);

    // Slave error on a read of a nonzero word, response held for 5 cycles
    xfer(1'b1, 32'h30, 32'h12345678, 1, 1'b0, 0);
    xfer(1'b0, 32'h30, 32'h0, 0, 1'b1, 5);

    // Randomised traffic
    for (int i = 0; i < 80; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
      waits = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(TMO - 3, TMO + 2);
      xfer(wr, addr, $urandom(), waits, ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    // Reset during ACCESS: transfer is dropped
    issue(1'b0, 32'h8, 32'h0, 1000, 1'b0, 0);
    n = 0;
    while (!(psel && penable)) begin
      @(negedge clk);
      n++;
      if (n > 20) begin
        fail_bound("reach_access");
        break;
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("req_ready_after_midreset", req_ready, 1'b1);

    xfer(1'b1, 32'h20, 32'hA5A55A5A, 1, 1'b0, 0);
    chk("ram_word8", ram[8], 32'hA5A55A5A);
    xfer(1'b0, 32'h20, 32'h0, 2, 1'b0, 1);

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
